// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered interrupt controller with claim/EOI handshake.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   irq            rising-edge triggered interrupt lines (NUM_IRQ wide)
//   hwint          registered interrupt request to the control unit
//   int_ack        one-cycle acknowledge from the control unit
//   rd, wr, addr   register strobes and select (0 PENDING, 1 ENABLE, 2 CLAIM, 3 EOI)
//   wdata, rdata   register write data / combinational read data
// Optional build macro INT_CTRL_SYNC_EN: adds a two-flop synchronizer on irq.
module int_ctrl #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               hwint,
    input  logic               int_ack,
    input  logic               rd,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    localparam logic [1:0] ADDR_PEND  = 2'd0;
    localparam logic [1:0] ADDR_EN    = 2'd1;
    localparam logic [1:0] ADDR_CLAIM = 2'd2;
    localparam logic [1:0] ADDR_EOI   = 2'd3;
    localparam logic [7:0] ID_NONE    = 8'hFF;

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] irq_s;
    logic [7:0]         claim_id;

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    // Two-flop synchronizer ahead of edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end
    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    // Upper wdata bits are only meaningful for wide configurations.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    logic [NUM_IRQ-1:0] edge_v;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] sel_oh;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [7:0]         sel_id;
    logic               sel_found;
    logic               ack_take;
    logic               eoi_wr;

    assign edge_v   = irq_s & ~irq_prev;
    assign w1c      = (wr && addr == ADDR_PEND) ? wdata[NUM_IRQ-1:0] : '0;
    // A same-cycle W1C is visible to the claim and to the request decision.
    assign active   = pending & ~w1c & enable;
    assign ack_take = (state == ASSERT) && int_ack;
    assign eoi_wr   = wr && addr == ADDR_EOI;

    // Lowest-index active source; descending scan so the lowest wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = ID_NONE;
        sel_oh    = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel_found = 1'b1;
                sel_id    = 8'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    // New edges win over W1C and ack clears of the same bit.
    assign ack_clr     = ack_take ? sel_oh : '0;
    assign pending_nxt = (pending & ~w1c & ~ack_clr) | edge_v;

    // Register file and IDLE/ASSERT/SERVICE sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hwint    <= 1'b0;
            pending  <= '0;
            enable   <= '0;
            claim_id <= ID_NONE;
            irq_prev <= irq_s;
        end else begin
            irq_prev <= irq_s;
            pending  <= pending_nxt;
            if (wr && addr == ADDR_EN) begin
                enable <= wdata[NUM_IRQ-1:0];
            end
            case (state)
                IDLE: begin
                    if (|active) begin
                        state <= ASSERT;
                        hwint <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (int_ack) begin
                        state    <= SERVICE;
                        hwint    <= 1'b0;
                        claim_id <= sel_found ? sel_id : ID_NONE;
                    end else if (!(|active)) begin
                        state <= IDLE;
                        hwint <= 1'b0;
                    end
                end
                SERVICE: begin
                    hwint <= 1'b0;
                    if (eoi_wr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    hwint <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read mux.
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (addr)
                ADDR_PEND:  rdata = 32'(pending);
                ADDR_EN:    rdata = 32'(enable);
                ADDR_CLAIM: rdata = {(state == SERVICE), 23'h0, claim_id};
                default:    rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed stimulus pushes expected values,
// a negedge monitor pops and compares read data and hwint.
module tb_int_ctrl;

    localparam logic [1:0] A_PEND  = 2'd0;
    localparam logic [1:0] A_EN    = 2'd1;
    localparam logic [1:0] A_CLAIM = 2'd2;
    localparam logic [1:0] A_EOI   = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        hwint;
    logic        int_ack;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hw_chk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rq_exp[$];
    string       rq_name[$];
    logic        hq_exp[$];
    string       hq_name[$];

    int_ctrl #(.NUM_IRQ(8)) dut (
        .clk(clk), .rst(rst), .irq(irq), .hwint(hwint), .int_ack(int_ack),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Monitor: compare whatever the stimulus flagged for this cycle.
    always @(negedge clk) begin
        if (rd) begin
            checks++;
            if (rq_exp.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected rdata=%h required=none", rdata);
            end else begin
                logic [31:0] e;
                string n;
                e = rq_exp.pop_front();
                n = rq_name.pop_front();
                if (rdata !== e) begin
                    failures++;
                    $display("FAIL %s rdata=%h required=%h", n, rdata, e);
                end
            end
        end
        if (hw_chk) begin
            checks++;
            if (hq_exp.size() == 0) begin
                failures++;
                $display("FAIL hw_unexpected hwint=%b required=none", hwint);
            end else begin
                logic e;
                string n;
                e = hq_exp.pop_front();
                n = hq_name.pop_front();
                if (hwint !== e) begin
                    failures++;
                    $display("FAIL %s hwint=%b required=%b", n, hwint, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd      = 1'b0;
        wr      = 1'b0;
        int_ack = 1'b0;
        hw_chk  = 1'b0;
    endtask

    task automatic exp_rd(input logic [1:0] a, input logic [31:0] e, input string n);
        rd   = 1'b1;
        addr = a;
        rq_exp.push_back(e);
        rq_name.push_back(n);
    endtask

    task automatic exp_hw(input logic e, input string n);
        hw_chk = 1'b1;
        hq_exp.push_back(e);
        hq_name.push_back(n);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq = 8'h00; int_ack = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 2'd0; wdata = 32'h0; hw_chk = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0; tick();

        // Reset state
        exp_hw(1'b0, "reset_hwint"); exp_rd(A_PEND, 32'h0, "reset_pending"); tick();
        exp_rd(A_EN, 32'h0, "reset_enable"); tick();
        exp_rd(A_CLAIM, 32'h0000_00FF, "reset_claim"); tick();

        // Single source: latency, ack, claim
        wr_reg(A_EN, 32'h1); tick();
        irq = 8'h01; tick();
        exp_hw(1'b0, "lat_hw_k"); exp_rd(A_PEND, 32'h1, "lat_pending_k"); tick();
        exp_hw(1'b1, "lat_hw_k1"); tick();
        int_ack = 1'b1; tick();
        exp_hw(1'b0, "ack_hw"); exp_rd(A_CLAIM, 32'h8000_0000, "ack_claim0"); tick();
        exp_rd(A_PEND, 32'h0, "ack_cleared"); tick();
        wr_reg(A_EOI, 32'h0); tick();
        exp_rd(A_CLAIM, 32'h0, "eoi_claim_held"); tick();
        int_ack = 1'b1; tick();
        exp_rd(A_CLAIM, 32'h0, "idle_ack_ignored"); exp_hw(1'b0, "idle_ack_hw"); tick();
        irq = 8'h00; tick();

        // Two simultaneous sources: lowest first, then the other after EOI
        wr_reg(A_EN, 32'hFFFF_FFFF); tick();
        exp_rd(A_EN, 32'h0000_00FF, "enable_upper_zero"); tick();
        irq = 8'h24; tick();
        tick();
        exp_hw(1'b1, "prio_hw"); tick();
        int_ack = 1'b1; tick();
        exp_rd(A_CLAIM, 32'h8000_0002, "prio_claim2"); exp_hw(1'b0, "prio_service_hw"); tick();
        exp_rd(A_PEND, 32'h20, "prio_pending"); tick();
        int_ack = 1'b1; tick();
        exp_rd(A_CLAIM, 32'h8000_0002, "service_ack_ignored"); tick();
        wr_reg(A_EOI, 32'h0); tick();
        exp_hw(1'b0, "post_eoi_idle_hw"); tick();
        exp_hw(1'b1, "post_eoi_hw"); tick();
        int_ack = 1'b1; tick();
        exp_rd(A_CLAIM, 32'h8000_0005, "prio_claim5"); tick();
        wr_reg(A_EOI, 32'h0); tick();
        irq = 8'h00; tick();

        // Pending while disabled, then enable
        wr_reg(A_EN, 32'h0); tick();
        irq = 8'h08; tick();
        tick();
        exp_rd(A_PEND, 32'h08, "dis_pending"); exp_hw(1'b0, "dis_hw"); tick();
        wr_reg(A_EN, 32'h08); tick();
        exp_hw(1'b0, "en_hw_1"); tick();
        exp_hw(1'b1, "en_hw_2"); tick();
        wr_reg(A_PEND, 32'h08); tick();
        exp_hw(1'b0, "w1c_b3_hw"); tick();
        exp_rd(A_PEND, 32'h0, "w1c_b3_pending"); tick();
        irq = 8'h00; tick();

        // W1C in ASSERT; W1C with same-cycle ack gives spurious id
        wr_reg(A_EN, 32'h1); tick();
        irq = 8'h01; tick();
        tick();
        exp_hw(1'b1, "w1c_pre_hw"); tick();
        wr_reg(A_PEND, 32'h01); tick();
        exp_hw(1'b0, "w1c_hw"); exp_rd(A_PEND, 32'h0, "w1c_pending"); tick();
        irq = 8'h00; tick();
        irq = 8'h01; tick();
        tick();
        exp_hw(1'b1, "spur_pre_hw"); tick();
        wr_reg(A_PEND, 32'h01); int_ack = 1'b1; tick();
        exp_hw(1'b0, "spur_hw"); exp_rd(A_CLAIM, 32'h8000_00FF, "spur_claim"); tick();
        wr_reg(A_EOI, 32'h0); tick();
        exp_rd(A_CLAIM, 32'h0000_00FF, "spur_eoi_claim"); tick();

        // Set event beats a same-bit W1C
        irq = 8'h00; tick();
        irq = 8'h01; wr_reg(A_PEND, 32'h01); tick();
        exp_rd(A_PEND, 32'h01, "set_beats_w1c"); tick();
        wr_reg(A_EN, 32'h0); tick();
        tick();
        exp_hw(1'b0, "disable_drop_hw"); tick();
        wr_reg(A_PEND, 32'hFF); tick();
        irq = 8'h00; tick();

        // Line high through reset release; reset during SERVICE
        rst = 1'b1; irq = 8'h02; tick(); tick();
        rst = 1'b0; tick(); tick(); tick();
        exp_rd(A_PEND, 32'h0, "held_line_no_edge"); tick();
        wr_reg(A_EN, 32'h1); tick();
        irq = 8'h03; tick();
        tick();
        int_ack = 1'b1; tick();
        exp_rd(A_CLAIM, 32'h8000_0000, "pre_rst_claim"); tick();
        rst = 1'b1; tick();
        exp_rd(A_CLAIM, 32'h0000_00FF, "rst_claim"); exp_hw(1'b0, "rst_hw"); tick();
        rst = 1'b0; tick();
        exp_rd(A_PEND, 32'h0, "rst_pending"); tick();
        exp_rd(A_EN, 32'h0, "rst_enable"); tick();

        tick();
        if (rq_exp.size() != 0 || hq_exp.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", rq_exp.size() + hq_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt sources (1..32).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port irq  input  NUM_IRQ  interrupt request lines, rising-edge triggered.
REQ-005 SHALL have port hwint  output  1  interrupt request to the control unit.
REQ-006 SHALL have port int_ack  input  1  one-cycle pulse from the control unit when it enters its hardware-interrupt entry state.
REQ-007 SHALL have port rd  input  1  register read strobe.
REQ-008 SHALL have port wr  input  1  register write strobe.
REQ-009 SHALL have port addr  input  2  register select.
REQ-010 SHALL have port wdata  input  32  write data.
REQ-011 SHALL have port rdata  output  32  read data.

Function
REQ-012 SHALL map registers: addr 0 PENDING (read; write-1-to-clear), addr 1 ENABLE (read/write), addr 2 CLAIM (read-only; bits[7:0] claimed id, bit31 in-service flag, other bits 0), addr 3 EOI (write-only, any data; reads 0).
REQ-013 SHALL drive rdata combinationally from addr when rd=1, else 32'h0; bits at or above NUM_IRQ in PENDING/ENABLE SHALL read 0.
REQ-014 SHALL set PENDING[i] on the clock edge where irq[i]=1 and the registered previous irq[i]=0, regardless of ENABLE[i].
REQ-015 SHALL give a same-bit set event priority over a simultaneous W1C clear or ack clear.
REQ-016 SHALL implement FSM states IDLE, ASSERT, SERVICE.
REQ-017 IDLE->ASSERT SHALL occur when (PENDING & ENABLE) != 0.
REQ-018 ASSERT->IDLE SHALL occur when (PENDING & ENABLE) == 0 and int_ack=0.
REQ-019 ASSERT->SERVICE SHALL occur on int_ack=1: CLAIM id <= lowest index i with PENDING[i]&ENABLE[i], PENDING[i] cleared; if none, CLAIM id <= 8'hFF (spurious).
REQ-020 SERVICE->IDLE SHALL occur on a write to EOI; EOI writes in IDLE/ASSERT SHALL be ignored.
REQ-021 SHALL ignore int_ack in IDLE and SERVICE.
REQ-022 hwint SHALL be a registered output equal to (state==ASSERT); no nesting: hwint=0 throughout SERVICE.
REQ-023 Latency: edge sampled at clock edge k (idle, enabled) -> PENDING set after k, hwint=1 after k+1.
REQ-024 CLAIM bit31 SHALL be 1 exactly while state==SERVICE; id SHALL hold its value after EOI until the next claim.

Reset
REQ-025 On rst=1 at a clock edge: state IDLE, hwint 0, PENDING 0, ENABLE 0, CLAIM id 8'hFF; registered previous irq loaded from irq, so lines already high at reset release SHALL NOT create a pending edge.
REQ-026 Reset mid-SERVICE or mid-ASSERT SHALL discard the claim and all pending bits with no EOI required.

Configuration
REQ-027 Macro INT_CTRL_SYNC_EN: when defined, irq SHALL pass through a two-flop synchronizer (reset to 0... loaded from synchronized value) before edge detection, adding 2 cycles to REQ-023 latency; when undefined, irq SHALL feed edge detection directly.

Verification
REQ-028 ENABLE=1, irq[0] 0->1 -> hwint=1 two cycles later; int_ack pulse -> hwint=0 next cycle, CLAIM reads 32'h8000_0000.
REQ-029 ENABLE=8'hFF, irq[5] and irq[2] rise same cycle -> ack claims id 2, PENDING reads 8'h20; EOI write -> hwint=1 again, next ack claims id 5.
REQ-030 ENABLE=0, irq[3] rises -> PENDING=8'h08, hwint stays 0; write ENABLE=8'h08 -> hwint=1 after 2 cycles.
REQ-031 In ASSERT, write PENDING with 8'h01 clearing the only pending bit -> state IDLE, hwint=0 next cycle; same-cycle ack instead -> CLAIM id 8'hFF.
REQ-032 irq[1] held high through rst release -> PENDING stays 0; rst asserted during SERVICE -> CLAIM reads 32'h0000_00FF next cycle, hwint 0.
